// File: rtl/lmdpl_dr_capture.sv
// Precharge/evaluate sequencer and masked-result capture for the first-order LMDPL AND gadget.
// Define LMDPL_CAPTURE_FAULT_EN to enable rail checking, timeout, the ERR state and the sticky fault flag.
`timescale 1ns/1ps

module lmdpl_dr_capture #(
  parameter int unsigned PRE_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 4
) (
  input  logic clk_i,
  input  logic rst_i,        // synchronous, active low
  input  logic in_valid_i,
  output logic in_ready_o,
  output logic precharge_o,
  input  logic x1_i,
  input  logic x2_i,
  input  logic x2_bar_i,
  output logic y1_o,
  output logic y2_o,
  output logic out_valid_o,
  input  logic out_ready_i,
  output logic fault_o
);

  // state | meaning
  // PRE   | gadget inputs held at 0 for PRE_CYCLES cycles, rails must settle to 00
  // IDLE  | precharged, accepting a new operation
  // EVAL  | gadget evaluating, waiting for a single-rail code on x2/x2_bar
  // OUT   | captured shares presented downstream
  // ERR   | invalid rail code or stuck evaluation, held until reset
  typedef enum logic [2:0] {
    S_PRE  = 3'd0,
    S_IDLE = 3'd1,
    S_EVAL = 3'd2,
    S_OUT  = 3'd3,
    S_ERR  = 3'd4
  } state_e;

  localparam logic [3:0] PRE_LAST = 4'(PRE_CYCLES - 1);
  localparam logic [3:0] TO_LAST  = 4'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       y1_q, y1_d;
  logic       y2_q, y2_d;
  logic [1:0] rails;

  assign rails = {x2_i, x2_bar_i};

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_PRE;
      cnt_q   <= 4'd0;
      y1_q    <= 1'b0;
      y2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y1_q    <= y1_d;
      y2_q    <= y2_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    y1_d    = y1_q;
    y2_d    = y2_q;
    case (state_q)
      S_PRE: begin
        if (cnt_q == PRE_LAST) begin
          cnt_d = 4'd0;
`ifdef LMDPL_CAPTURE_FAULT_EN
          state_d = (rails == 2'b00) ? S_IDLE : S_ERR;
`else
          state_d = S_IDLE;
`endif
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_IDLE: begin
`ifdef LMDPL_CAPTURE_FAULT_EN
        if (rails != 2'b00) begin
          state_d = S_ERR;
        end else
`endif
        if (in_valid_i) begin
          state_d = S_EVAL;
          cnt_d   = 4'd0;
        end
      end
      S_EVAL: begin
`ifdef LMDPL_CAPTURE_FAULT_EN
        // The TIMEOUT-th cycle fails even if a code arrives on it.
        if (cnt_q == TO_LAST || rails == 2'b11) begin
          state_d = S_ERR;
        end else if (rails == 2'b00) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          y1_d    = x1_i;
          y2_d    = x2_i;
          state_d = S_OUT;
        end
`else
        if (rails == 2'b00) begin
          if (cnt_q != TO_LAST) begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          y1_d    = x1_i;
          y2_d    = x2_i;
          state_d = S_OUT;
        end
`endif
      end
      S_OUT: begin
        if (out_ready_i) begin
          state_d = S_PRE;
          cnt_d   = 4'd0;
        end
      end
      default: begin
`ifdef LMDPL_CAPTURE_FAULT_EN
        state_d = S_ERR;
`else
        state_d = S_PRE;
`endif
      end
    endcase
  end

  always_comb begin
    precharge_o = 1'b1;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    fault_o     = 1'b0;
    case (state_q)
      S_IDLE: in_ready_o  = 1'b1;
      S_EVAL: precharge_o = 1'b0;
      S_OUT:  out_valid_o = 1'b1;
`ifdef LMDPL_CAPTURE_FAULT_EN
      S_ERR:  fault_o     = 1'b1;
`endif
      default: ;
    endcase
  end

  assign y1_o = y1_q;
  assign y2_o = y2_q;

endmodule

// File: doc/lmdpl_dr_capture.md
# lmdpl_dr_capture

Downstream sequencing and capture stage for the first-order LMDPL AND gadget. Drives the gadget's precharge/evaluate phase and waits for the dual-rail output pair (x2, x2_bar) to leave the all-zero precharge code. Captures the masked result together with its mask share and returns it as a registered Boolean-masked pair over a valid/ready handshake. Invalid dual-rail codes and stuck evaluations are flagged as faults.

## Interface
- PRE_CYCLES, 2: cycles the precharge phase is held before a new operation is accepted (1..15).
- TIMEOUT, 4: maximum EVAL cycles allowed without a single-rail code (1..15).
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset: rst=0 at a rising edge resets the block.
- in_valid  in  1  upstream has operands ready; high means it will drive a2/b2 dual-rail values while precharge=0.
- in_ready  out  1  block accepts an operation this cycle.
- precharge  out  1  1 = upstream must drive all dual-rail gadget inputs to 0.
- x1  in  1  mask share from the gadget; stable for the whole EVAL phase.
- x2, x2_bar  in  1 each  dual-rail masked share from the gadget.
- y1, y2  out  1 each  captured result shares, y = y1 ^ y2.
- out_valid  out  1  y1/y2 valid.
- out_ready  in  1  downstream accepts y1/y2.
- fault  out  1  sticky error flag.

## Operation
- FSM states: PRE, IDLE, EVAL, OUT, ERR.
- PRE: precharge=1. A 4-bit counter counts PRE_CYCLES cycles. On the last PRE cycle, the rails must read {x2,x2_bar}=00. If they do, go to IDLE; otherwise go to ERR.
- IDLE: precharge=1, in_ready=1. If the rails read anything other than 00, go to ERR. On in_valid=1, go to EVAL and clear the counter.
- EVAL: precharge=0, in_ready=0. The rails are sampled every cycle.
  - 00: stay in EVAL and increment the counter. On the TIMEOUT-th consecutive 00 cycle, go to ERR.
  - 10 or 01: register y2<=x2 and y1<=x1, then go to OUT.
  - 11: go to ERR.
- OUT: precharge=1, out_valid=1. y1/y2 stay constant. On out_ready=1, go to PRE with the counter cleared.
- ERR: fault=1 until reset, precharge=1, in_ready=0, out_valid=0. y1/y2 keep their last value.
- y1/y2 are loaded only in EVAL on a single-rail code. They are never loaded from precharge or invalid codes, so no unmasked combination is registered.
- Reset values: state=PRE, counter=0, precharge=1, in_ready=0, out_valid=0, y1=0, y2=0, fault=0.
- Reset mid-operation (any state, including ERR) returns the block to PRE. Any in-flight result is discarded.

## Timing
- in_valid sampled high in IDLE at edge k → EVAL from cycle k+1 (precharge falls at k+1).
- First single-rail code sampled at edge e → out_valid=1 from cycle e+1.
- Minimum latency from in_valid acceptance to out_valid: 2 cycles.
- OUT handshake at edge h → PRE from h+1 → in_ready=1 again at h+1+PRE_CYCLES.
- Back-to-back throughput: one operation per PRE_CYCLES+3 cycles minimum.
- in_valid is ignored outside IDLE. out_ready is ignored outside OUT.
- Event priority within a cycle: rst over everything, then a fault condition over a state transition.
- TIMEOUT boundary: with TIMEOUT=4, a valid code on the 4th EVAL cycle is rejected, since that cycle completes the 4th consecutive 00 count. A valid code on the 3rd EVAL cycle is captured.

## Configuration
- LMDPL_CAPTURE_FAULT_EN defined:
  - full checking: rail check in PRE/IDLE, timeout, 11 detection, ERR state, sticky fault.
- LMDPL_CAPTURE_FAULT_EN undefined:
  - ERR state and timeout logic are removed and fault is tied to 0.
  - PRE always proceeds to IDLE.
  - EVAL waits indefinitely for a non-00 code.
  - A code of 11 is captured as y2=1.

## Test plan
- Reset: hold rst=0 for 2 cycles → all outputs 0 and precharge=1. Release rst → in_ready=1 after PRE_CYCLES=2 cycles with rails 00.
- Nominal: x1=1, in_valid pulse, rails 10 on the 1st EVAL cycle → out_valid=1 one cycle later, y1=1, y2=1 (y=0). Hold out_ready=0 for 3 cycles → y1/y2 remain stable. Then out_ready=1 → PRE.
- Delayed eval: rails 00 for 2 EVAL cycles, then 01 with x1=0 → y1=0, y2=0, fault=0. Rails 00 for 4 EVAL cycles with TIMEOUT=4 → fault=1 with out_valid=0.
- Invalid code: rails 11 in EVAL → fault=1 next cycle and stays high until rst=0.
- Precharge violation: x2=1 during IDLE → fault=1. Repeat with the macro undefined → fault stays 0, and a code of 11 in EVAL yields y2=1.
- Reset mid-EVAL: rst=0 during EVAL → next cycle state PRE, out_valid=0, precharge=1, no result emitted.
